// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel scanner: scan states and the
// channel layout of a packed framebuffer word (R1,G1,B1,R2,G2,B2, MSB first).
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    SHIFT    = 3'd2,
    BLANK    = 3'd3,
    LATCH    = 3'd4,
    DISPLAY  = 3'd5
  } state_t;

  localparam int NUM_CH = 6;
  localparam int CH_R1  = 0;
  localparam int CH_G1  = 1;
  localparam int CH_B1  = 2;
  localparam int CH_R2  = 3;
  localparam int CH_G2  = 4;
  localparam int CH_B2  = 5;

  // Bit offset of a channel field inside the packed word; R1 sits at the top.
  function automatic int field_lsb(input int ch, input int color_bits);
    return (NUM_CH - 1 - ch) * color_bits;
  endfunction

endpackage

// File: rtl/hub75_scanner.sv
// HUB75 panel scanner: shifts one bit plane of a row pair per pass out of a
// synchronous-read framebuffer, latches it and lights it for BASE_TICKS<<plane cycles.
module hub75_scanner
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROW_PAIRS  = 16,
  parameter int COLOR_BITS = 4,
  parameter int BASE_TICKS = 8,
  localparam int ADDR_WIDTH = $clog2(COLS * ROW_PAIRS),
  localparam int DATA_WIDTH = 6 * COLOR_BITS,
  localparam int ROW_BITS   = $clog2(ROW_PAIRS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  r1,
  output logic                  g1,
  output logic                  b1,
  output logic                  r2,
  output logic                  g2,
  output logic                  b2,
  output logic                  hub_clk,
  output logic                  hub_lat,
  output logic                  hub_oe_n,
  output logic [ROW_BITS-1:0]   hub_row,
  output logic                  frame_done
);

  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int TICK_W  = $clog2(BASE_TICKS << (COLOR_BITS - 1)) + 1;

  state_t              state_r;
  logic [COL_W-1:0]    col_r;
  logic                phase_r;
  logic [PLANE_W-1:0]  plane_r;
  logic [ROW_BITS-1:0] rp_r;
  logic [TICK_W-1:0]   tick_r;

  logic                plane_last_s;
  logic                rp_last_s;
  logic                frame_wrap_s;
  logic [PLANE_W-1:0]  plane_nxt_s;
  logic [ROW_BITS-1:0] rp_nxt_s;
  logic [TICK_W-1:0]   tick_last_s;
  logic [5:0]          pix_s;

  function automatic logic plane_bit(input logic [DATA_WIDTH-1:0] word, input int ch,
                                     input int plane);
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> (field_lsb(ch, COLOR_BITS) + plane);
    return sh[0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] row_base(input logic [ROW_BITS-1:0] rp);
    return ADDR_WIDTH'(rp) * ADDR_WIDTH'(COLS);
  endfunction

  // Counter successors for the end of DISPLAY and the current plane's colour bits
  always_comb begin
    plane_last_s = (plane_r == PLANE_W'(COLOR_BITS - 1));
    rp_last_s    = (rp_r == ROW_BITS'(ROW_PAIRS - 1));
    frame_wrap_s = plane_last_s && rp_last_s;
    plane_nxt_s  = plane_last_s ? '0 : plane_r + PLANE_W'(1);
    rp_nxt_s     = plane_last_s ? (rp_last_s ? '0 : rp_r + ROW_BITS'(1)) : rp_r;
    tick_last_s  = (TICK_W'(BASE_TICKS) << plane_r) - TICK_W'(1);
    pix_s = {plane_bit(rd_data, CH_R1, int'(plane_r)), plane_bit(rd_data, CH_G1, int'(plane_r)),
             plane_bit(rd_data, CH_B1, int'(plane_r)), plane_bit(rd_data, CH_R2, int'(plane_r)),
             plane_bit(rd_data, CH_G2, int'(plane_r)), plane_bit(rd_data, CH_B2, int'(plane_r))};
  end

  // Scan sequencer; every panel-facing output is a register set for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      col_r      <= '0;
      phase_r    <= 1'b0;
      plane_r    <= '0;
      rp_r       <= '0;
      tick_r     <= '0;
      rd_addr    <= '0;
      {r1, g1, b1, r2, g2, b2} <= 6'b000000;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          hub_oe_n <= 1'b1;
          hub_clk  <= 1'b0;
          hub_lat  <= 1'b0;
          // Address is issued on entry so column 0 data lands two cycles later
          if (enable) begin
            state_r <= PREFETCH;
            rd_addr <= row_base(rp_r);
          end else begin
            state_r <= IDLE;
          end
        end
        PREFETCH: begin
          col_r   <= '0;
          phase_r <= 1'b0;
          state_r <= SHIFT;
        end
        SHIFT: begin
          if (!phase_r) begin
            {r1, g1, b1, r2, g2, b2} <= pix_s;
            hub_clk <= 1'b0;
            phase_r <= 1'b1;
            if (col_r != COL_W'(COLS - 1)) begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
          end else begin
            hub_clk <= 1'b1;
            phase_r <= 1'b0;
            if (col_r == COL_W'(COLS - 1)) begin
              state_r <= BLANK;
            end else begin
              col_r <= col_r + COL_W'(1);
            end
          end
        end
        BLANK: begin
          hub_clk <= 1'b0;
          hub_lat <= 1'b1;
          hub_row <= rp_r;
          state_r <= LATCH;
        end
        LATCH: begin
          hub_lat  <= 1'b0;
          hub_oe_n <= 1'b0;
          tick_r   <= '0;
          state_r  <= DISPLAY;
        end
        DISPLAY: begin
          if (tick_r == tick_last_s) begin
            hub_oe_n   <= 1'b1;
            plane_r    <= plane_nxt_s;
            rp_r       <= rp_nxt_s;
            frame_done <= frame_wrap_s;
            if (enable) begin
              state_r <= PREFETCH;
              rd_addr <= row_base(rp_nxt_s);
            end else begin
              state_r <= IDLE;
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end
        default: begin
          hub_oe_n <= 1'b1;
          hub_clk  <= 1'b0;
          hub_lat  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
